// File: rtl/dice_pkg.sv
// Shared dice encodings, per-die maximum face lookup and the sequencer state set.
// dice_roller and dice_roll_sequencer both use these codes so die_select means the same thing on each side.
package dice_pkg;

  localparam logic [1:0] D4  = 2'b00;
  localparam logic [1:0] D6  = 2'b01;
  localparam logic [1:0] D8  = 2'b10;
  localparam logic [1:0] D20 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ROLL = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic [7:0] die_max(input logic [1:0] die);
    logic [7:0] m;
    case (die)
      D4:      m = 8'd4;
      D6:      m = 8'd6;
      D8:      m = 8'd8;
      default: m = 8'd20;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dice_roll_sequencer.sv
// Issues one roll pulse per requested die to dice_roller, samples each result a fixed
// latency later, range-checks it and accumulates the total, finishing with a done pulse.
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int ROLL_LATENCY = 2,
  parameter int NDICE_W      = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [NDICE_W-1:0] num_dice,
  input  logic [1:0]         die_type,
  output logic [1:0]         die_select,
  output logic               roll,
  input  logic [7:0]         rolled_number,
  output logic               busy,
  output logic               done,
  output logic [7:0]         total,
  output logic               range_err,
  output state_e             dbg_state
);

  // Handshake: start is a level sampled only in IDLE; done is a single-cycle
  // qualifier for total/range_err, and busy covers acceptance through DONE.

  localparam int WAIT_W = 3;
  localparam logic [WAIT_W-1:0] LAT = WAIT_W'(ROLL_LATENCY);

  state_e             state_q, state_d;
  logic [NDICE_W-1:0] remaining_q, remaining_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]         acc_q, acc_d;
  logic [1:0]         die_select_d;
  logic               roll_d, busy_d, done_d, range_err_d;
  logic [7:0]         total_d;
  logic               in_range;
  logic [7:0]         acc_plus;

  assign dbg_state = state_q;
  assign in_range  = (rolled_number != 8'd0) && (rolled_number <= die_max(die_select));
  assign acc_plus  = acc_q + rolled_number;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      acc_q       <= 8'd0;
      die_select  <= D4;
      roll        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      total       <= 8'd0;
      range_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      acc_q       <= acc_d;
      die_select  <= die_select_d;
      roll        <= roll_d;
      busy        <= busy_d;
      done        <= done_d;
      total       <= total_d;
      range_err   <= range_err_d;
    end
  end

  // Outputs are registered: each branch sets the value the output takes in the state being entered.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    wait_cnt_d   = wait_cnt_q;
    acc_d        = acc_q;
    die_select_d = die_select;
    roll_d       = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    total_d      = total;
    range_err_d  = range_err;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ROLL;
          roll_d       = 1'b1;
          busy_d       = 1'b1;
          die_select_d = die_type;
          remaining_d  = (num_dice == '0) ? NDICE_W'(1) : num_dice;
          acc_d        = 8'd0;
          range_err_d  = 1'b0;
          wait_cnt_d   = '0;
        end
      end

      ROLL: begin
        state_d    = WAIT;
        wait_cnt_d = LAT;
      end

      WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_q == WAIT_W'(1)) begin
          if (in_range) begin
            acc_d = acc_plus;
          end else begin
            range_err_d = 1'b1;
          end
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == NDICE_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            total_d = in_range ? acc_plus : acc_q;
          end else begin
            state_d = ROLL;
            roll_d  = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/dice_roll_sequencer.md
Name: dice_roll_sequencer

Overview:
Initiator/consumer for dice_roller: takes a roll request "N dice of type D", drives dice_roller's die_select/roll inputs once per die, samples rolled_number after a fixed latency, range-checks it, and accumulates the sum. Sits between the user-input front end (buttons/DIP switches) and dice_roller. Presents the final total with a one-cycle done pulse.

Parameters:
ROLL_LATENCY, 2, cycles from the edge at which dice_roller samples roll=1 to the edge at which rolled_number is sampled (legal 1..7)
NDICE_W, 3, width of num_dice; max dice per request = 2**NDICE_W-1 = 7

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request pulse, sampled only in IDLE
num_dice  input  NDICE_W  dice count; 0 is treated as 1
die_type  input  2  00=d4, 01=d6, 10=d8, 11=d20
die_select  output  2  to dice_roller, registered
roll  output  1  to dice_roller, registered, one-cycle pulse per die
rolled_number  input  8  from dice_roller
busy  output  1  high from start acceptance until DONE exits
done  output  1  one-cycle pulse, total valid
total  output  8  sum of accepted rolls (max 7*20=140, no overflow)
range_err  output  1  sticky per request: some sample was 0 or > die max

Behaviour:
- Reset (async, immediate): state=IDLE; roll=0, die_select=00, busy=0, done=0, total=0, range_err=0; accumulator and counters cleared. Reset mid-request aborts it with no done pulse.
- States: IDLE, ROLL, WAIT, DONE.
- IDLE: busy=0. On start=1 at edge E0: latch die_type into die_select, remaining=max(num_dice,1), acc=0, range_err=0, wait_cnt cleared, go to ROLL. busy=1 from E0.
- ROLL (one cycle): roll=1. At the next edge, roll returns to 0, wait_cnt=ROLL_LATENCY, go to WAIT.
- WAIT: decrement wait_cnt each cycle. On the edge where wait_cnt==1, sample rolled_number:
  - in range (1..DIE_MAX[die_select]): acc += rolled_number;
  - otherwise: range_err=1 and the value is not added;
  - remaining -= 1; if remaining becomes 0, go to DONE, else go to ROLL.
- Per-die cost: 1+ROLL_LATENCY cycles. DONE is entered at E0 + N*(1+ROLL_LATENCY).
- DONE (one cycle): done=1 and total=acc; next state IDLE; busy drops with done.
- total and range_err hold until the next accepted start (range_err clears) or the next DONE (total updates).
- start while busy, or during DONE, is ignored; there is no queueing.
- die_type and num_dice are sampled only at acceptance; later changes have no effect on the request in flight.
- die_select is stable for the whole request and changes only at acceptance.
- Width rules:
  - acc is 8-bit unsigned; the maximum legal sum of 140 cannot overflow.
  - Out-of-range values are excluded, so 8 bits always suffice.

Decomposition:
- Shared package dice_pkg:
  - die encodings D4=2'b00, D6=2'b01, D8=2'b10, D20=2'b11;
  - DIE_MAX lookup function (4,6,8,20);
  - state enum {IDLE,ROLL,WAIT,DONE}.
- dice_roller should use the same package encodings.
- No sub-module: a single FSM with two counters.
- Bench instantiates either a mock roller (programmable return value, fixed latency) or the real dice_roller.

Test Plan:
- Mock returns 5; start with num_dice=3, die_type=01, ROLL_LATENCY=2 at E0 -> exactly 3 roll pulses at E0+1, E0+4, E0+7 (one cycle each); done at cycle E0+9; total=15; range_err=0.
- num_dice=0, die_type=11, mock returns 13 -> exactly one roll pulse; total=13; done after 3 cycles.
- num_dice=7, die_type=11, mock returns 20 -> total=140, no wrap.
- die_type=00, mock returns 0 then 3 then 5 for num_dice=3 -> range_err=1, total=3. Next request with in-range values -> range_err=0.
- start held high throughout a 2-die request -> only 2 roll pulses per request. A new request is accepted only on the cycle after done. busy is never 1 in IDLE.
- reset_n pulled low during WAIT of die 2 -> roll, busy, done, total all 0 immediately; no done pulse afterward. After release, a fresh request completes normally.
- Real dice_roller, 100 random requests -> range_err=0 and total within [N, N*DIE_MAX].
